uart_rx: RTL and testbench

//  8N1 UART receiver; upstream stage of led_controller. Synchronises the async

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// uart_tx is expected to reuse this package when it is written.
package uart_rx_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitIdle = 3'd4;

  // 12 MHz system clock, 9600 baud
  localparam int unsigned ClksPerBitDefault = 1250;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Resets to 1 so an idle-high line never looks like a start bit after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_s_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, single mid-bit sample per bit,
// one-cycle rx_done strobe for good bytes and frame_err strobe for bad stop bits.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      // Re-check the line half a bit in; a high here was a glitch, not a start bit.
      StStart: begin
        if (clk_cnt_q == CntHalf) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (clk_cnt_q == CntFull) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // Leaving mid stop bit lets a start edge right after the stop bit be caught.
      StStop: begin
        if (clk_cnt_q == CntFull) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            rx_byte_d = shift_q;
            rx_done_d = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must not be mistaken for a new start bit.
      StWaitIdle: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_byte_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected bytes / frame errors,
// a negedge monitor pops and compares whenever rx_done or frame_err pulses.
module tb_uart_rx;

  localparam int unsigned Clks = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];
  int         ferr_sent;
  int         ferr_seen;
  logic [7:0] last_good;
  logic       prev_done;
  logic       prev_ferr;

  uart_rx #(
    .CLKS_PER_BIT (Clks)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares DUT strobes against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_good = 8'h00;
      prev_done = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (rx_done) begin
        n_checks++;
        if (frame_err) begin
          n_errors++;
          $display("FAIL done_and_ferr: both strobes high, required mutually exclusive");
        end
        n_checks++;
        if (prev_done) begin
          n_errors++;
          $display("FAIL done_width: rx_done high 2+ cycles, required 1");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_done: rx_byte=%02h, no byte expected", rx_byte);
        end else begin
          logic [7:0] exp_b;
          exp_b = exp_q.pop_front();
          if (rx_byte !== exp_b) begin
            n_errors++;
            $display("FAIL rx_byte: got %02h, required %02h", rx_byte, exp_b);
          end
          last_good = exp_b;
        end
      end
      if (frame_err) begin
        n_checks++;
        if (prev_ferr) begin
          n_errors++;
          $display("FAIL ferr_width: frame_err high 2+ cycles, required 1");
        end
        n_checks++;
        if (ferr_seen >= ferr_sent) begin
          n_errors++;
          $display("FAIL unexpected_ferr: frame_err=1, required 0");
        end
        ferr_seen++;
        n_checks++;
        if (rx_byte !== last_good) begin
          n_errors++;
          $display("FAIL ferr_hold: rx_byte=%02h, required %02h", rx_byte, last_good);
        end
      end
      prev_done = rx_done;
      prev_ferr = frame_err;
    end
  end

  // Called at a negedge; holds the level for one bit period.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (Clks) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) exp_q.push_back(b);
    else ferr_sent++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * Clks; i++) begin
      if (exp_q.size() == 0 && ferr_seen == ferr_sent) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0 || ferr_seen != ferr_sent) begin
      n_errors++;
      $display("FAIL %s: pending bytes=%0d ferr=%0d, required 0 and 0", name,
               exp_q.size(), ferr_sent - ferr_seen);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] a5;
    n_checks  = 0;
    n_errors  = 0;
    ferr_sent = 0;
    ferr_seen = 0;
    rst_n     = 1'b0;
    rx        = 1'b1;
    repeat (3) @(negedge clk);
    check_byte("reset_rx_byte", rx_byte, 8'h00);
    check_bit("reset_rx_done", rx_done, 1'b0);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (Clks) @(negedge clk);

    // 1. single frame
    send_byte(8'h52, 1'b1);
    wait_drain("drain_52");

    // 2. back-to-back frames, no idle gap
    send_byte(8'h47, 1'b1);
    send_byte(8'h67, 1'b1);
    wait_drain("drain_47_67");
    repeat (Clks) @(negedge clk);

    // 3. short glitch must be rejected
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    begin
      int k;
      k = 0;
      while (busy && k < 10) begin
        @(negedge clk);
        k++;
      end
      check_bit("glitch_busy_drop", busy, 1'b0);
    end
    repeat (Clks) @(negedge clk);

    // 4. bad stop bit, then a break, then a good frame
    send_byte(8'h42, 1'b0);
    repeat (40) @(negedge clk);
    check_bit("break_busy", busy, 1'b1);
    wait_drain("drain_ferr");
    rx = 1'b1;
    repeat (Clks) @(negedge clk);
    check_bit("break_release_busy", busy, 1'b0);
    send_byte(8'h62, 1'b1);
    wait_drain("drain_62");
    repeat (Clks) @(negedge clk);

    // 5. asynchronous reset during bit 3 of 0xA5
    a5 = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(a5[i]);
    rx = a5[3];
    repeat (Clks / 2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_byte("midreset_rx_byte", rx_byte, 8'h00);
    check_bit("midreset_rx_done", rx_done, 1'b0);
    check_bit("midreset_frame_err", frame_err, 1'b0);
    check_bit("midreset_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (Clks) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    wait_drain("drain_a5");

    // 6. all-zero and all-one payloads
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_drain("drain_00_ff");
    repeat (3 * Clks) @(negedge clk);
    check_byte("final_rx_byte", rx_byte, 8'hFF);
    check_bit("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
